// File: rtl/ctrl_fsm_mc_if.sv
// Handshake bundle between the multi-cycle controller and its IFU, LSU and MDU peers.
// The master modport is the controller side; slave is the environment side.
interface ctrl_fsm_mc_if;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_resp_valid;
    logic        mdu_start;
    logic        mdu_done;

    modport master (
        input  inst_valid, inst, lsu_req_ready, lsu_resp_valid, mdu_done,
        output inst_ready, lsu_req_valid, mdu_start
    );

    modport slave (
        output inst_valid, inst, lsu_req_ready, lsu_resp_valid, mdu_done,
        input  inst_ready, lsu_req_valid, mdu_start
    );
endinterface

// File: rtl/ctrl_fsm_mc.sv
// Multi-cycle RV32I/M control unit: latches one instruction, decodes it into a
// registered control bundle and walks EXEC / MEM / MDU / WB phases, trapping on illegal encodings.
module ctrl_fsm_mc #(
    parameter bit EN_MEXT  = 1'b1,
    parameter int MEMOP_W  = 3,
    parameter int ALUCTR_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    ctrl_fsm_mc_if.master       bus,
    output logic [2:0]          ExtOp,
    output logic                ALUAsrc,
    output logic [1:0]          ALUBsrc,
    output logic [ALUCTR_W-1:0] ALUctr,
    output logic [2:0]          Branch,
    output logic                MemtoReg,
    output logic                MemWr,
    output logic [MEMOP_W-1:0]  MemOp,
    output logic [2:0]          MduOp,
    output logic                RegWr,
    output logic                PcWr,
    output logic                illegal,
    output logic                busy
);
    typedef enum logic [2:0] {
        IDLE, DECODE, EXEC, MEM_REQ, MEM_WAIT, MDU_WAIT, WB, TRAP
    } state_t;

    typedef struct packed {
        logic [2:0]          ext_op;
        logic                alu_asrc;
        logic [1:0]          alu_bsrc;
        logic [ALUCTR_W-1:0] alu_ctr;
        logic [2:0]          branch;
        logic                mem_to_reg;
        logic                mem_wr;
        logic [MEMOP_W-1:0]  mem_op;
        logic [2:0]          mdu_op;
        logic                reg_wr_en;
        logic                is_mem;
        logic                is_mop;
    } bundle_t;

    state_t      state_reg, state_next;
    logic [31:0] inst_reg;
    bundle_t     bundle_reg, dec;
    logic        legal;
    logic        trap_first_reg;
    logic        unused_bits;

    logic [4:0] opc;
    logic [2:0] func3;
    logic [6:0] func7;
    assign opc         = inst_reg[6:2];
    assign func3       = inst_reg[14:12];
    assign func7       = inst_reg[31:25];
    assign unused_bits = ^{inst_reg[24:15], inst_reg[11:7]};

    // Same ALUctr encoding as the single-cycle controller.
    function automatic logic [ALUCTR_W-1:0] alu_code(input logic [2:0] f3, input logic alt);
        logic [3:0] code;
        case (f3)
            3'b000:  code = alt ? 4'b1000 : 4'b0000;
            3'b001:  code = 4'b0001;
            3'b010:  code = 4'b0010;
            3'b011:  code = 4'b1010;
            3'b100:  code = 4'b0100;
            3'b101:  code = alt ? 4'b1101 : 4'b0101;
            3'b110:  code = 4'b0110;
            default: code = 4'b0111;
        endcase
        return ALUCTR_W'(code);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            inst_reg       <= '0;
            bundle_reg     <= '0;
            trap_first_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            trap_first_reg <= (state_reg == DECODE) && !legal;
            if (state_reg == IDLE && bus.inst_valid)
                inst_reg <= bus.inst;
            if (state_reg == DECODE && legal)
                bundle_reg <= dec;
            else if (state_reg == WB)
                bundle_reg <= '0;
        end
    end

    always_comb begin
        dec   = '0;
        legal = 1'b0;
        if (inst_reg[1:0] == 2'b11) begin
            case (opc)
                5'b01101: begin // lui
                    legal = 1'b1; dec.ext_op = 3'b001; dec.alu_bsrc = 2'b01;
                    dec.alu_ctr = ALUCTR_W'(4'b0011); dec.reg_wr_en = 1'b1;
                end
                5'b00101: begin // auipc
                    legal = 1'b1; dec.ext_op = 3'b001; dec.alu_asrc = 1'b1;
                    dec.alu_bsrc = 2'b01; dec.reg_wr_en = 1'b1;
                end
                5'b00100: begin
                    legal = 1'b1; dec.alu_bsrc = 2'b01; dec.reg_wr_en = 1'b1;
                    dec.alu_ctr = alu_code(func3, (func3 == 3'b101) && func7[5]);
                end
                5'b01100: begin
                    dec.reg_wr_en = 1'b1;
                    if (func7 == 7'b0000001) begin
                        legal = EN_MEXT; dec.is_mop = 1'b1; dec.mdu_op = func3;
                    end else begin
                        legal = 1'b1; dec.alu_ctr = alu_code(func3, func7[5]);
                    end
                end
                5'b11011: begin // jal
                    legal = 1'b1; dec.ext_op = 3'b100; dec.alu_asrc = 1'b1;
                    dec.alu_bsrc = 2'b10; dec.branch = 3'b001; dec.reg_wr_en = 1'b1;
                end
                5'b11001: begin // jalr
                    legal = 1'b1; dec.alu_asrc = 1'b1; dec.alu_bsrc = 2'b10;
                    dec.branch = 3'b010; dec.reg_wr_en = 1'b1;
                end
                5'b11000: begin
                    legal = (func3[2:1] != 2'b01); dec.ext_op = 3'b011;
                    dec.alu_ctr = func3[1] ? ALUCTR_W'(4'b1010) : ALUCTR_W'(4'b0010);
                    dec.branch = {1'b1, func3[2], func3[0]};
                end
                5'b00000: begin
                    legal = (func3 != 3'b011) && (func3 != 3'b110) && (func3 != 3'b111);
                    dec.alu_bsrc = 2'b01; dec.mem_to_reg = 1'b1; dec.is_mem = 1'b1;
                    dec.mem_op = MEMOP_W'(func3); dec.reg_wr_en = 1'b1;
                end
                5'b01000: begin
                    legal = (func3 < 3'b011); dec.ext_op = 3'b010; dec.alu_bsrc = 2'b01;
                    dec.mem_wr = 1'b1; dec.is_mem = 1'b1; dec.mem_op = MEMOP_W'(func3);
                end
                default: legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (bus.inst_valid) state_next = DECODE;
            DECODE:   state_next = legal ? EXEC : TRAP;
            EXEC:     state_next = bundle_reg.is_mem ? MEM_REQ :
                                   bundle_reg.is_mop ? MDU_WAIT : WB;
            MEM_REQ:  if (bus.lsu_req_ready) state_next = MEM_WAIT;
            MEM_WAIT: if (bus.lsu_resp_valid) state_next = WB;
            MDU_WAIT: if (bus.mdu_done) state_next = WB;
            WB:       state_next = IDLE;
            TRAP:     state_next = TRAP;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.inst_ready    = (state_reg == IDLE) && !rst;
        bus.lsu_req_valid = (state_reg == MEM_REQ);
        bus.mdu_start     = (state_reg == EXEC) && bundle_reg.is_mop;
        busy              = (state_reg != IDLE);
        illegal           = (state_reg == TRAP);
        RegWr             = (state_reg == WB) && bundle_reg.reg_wr_en;
        PcWr              = (state_reg == WB) || ((state_reg == TRAP) && trap_first_reg);
        ExtOp             = bundle_reg.ext_op;
        ALUAsrc           = bundle_reg.alu_asrc;
        ALUBsrc           = bundle_reg.alu_bsrc;
        ALUctr            = bundle_reg.alu_ctr;
        Branch            = bundle_reg.branch;
        MemtoReg          = bundle_reg.mem_to_reg;
        MemWr             = bundle_reg.mem_wr;
        MemOp             = bundle_reg.mem_op;
        MduOp             = bundle_reg.mdu_op;
    end
endmodule

// File: tb/tb_ctrl_fsm_mc.sv
// Directed bench for ctrl_fsm_mc: one DUT with the M extension, one without.
module tb_ctrl_fsm_mc;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    ctrl_fsm_mc_if bif();
    ctrl_fsm_mc_if bif0();

    logic [2:0] ExtOp, ExtOp_b;
    logic       ALUAsrc, ALUAsrc_b;
    logic [1:0] ALUBsrc, ALUBsrc_b;
    logic [3:0] ALUctr, ALUctr_b;
    logic [2:0] Branch, Branch_b;
    logic       MemtoReg, MemtoReg_b, MemWr, MemWr_b;
    logic [2:0] MemOp, MemOp_b, MduOp, MduOp_b;
    logic       RegWr, RegWr_b, PcWr, PcWr_b, illegal, illegal_b, busy, busy_b;

    ctrl_fsm_mc #(.EN_MEXT(1'b1), .MEMOP_W(3), .ALUCTR_W(4)) dut (
        .clk(clk), .rst(rst), .bus(bif),
        .ExtOp(ExtOp), .ALUAsrc(ALUAsrc), .ALUBsrc(ALUBsrc), .ALUctr(ALUctr),
        .Branch(Branch), .MemtoReg(MemtoReg), .MemWr(MemWr), .MemOp(MemOp),
        .MduOp(MduOp), .RegWr(RegWr), .PcWr(PcWr), .illegal(illegal), .busy(busy)
    );

    ctrl_fsm_mc #(.EN_MEXT(1'b0), .MEMOP_W(3), .ALUCTR_W(4)) dut0 (
        .clk(clk), .rst(rst), .bus(bif0),
        .ExtOp(ExtOp_b), .ALUAsrc(ALUAsrc_b), .ALUBsrc(ALUBsrc_b), .ALUctr(ALUctr_b),
        .Branch(Branch_b), .MemtoReg(MemtoReg_b), .MemWr(MemWr_b), .MemOp(MemOp_b),
        .MduOp(MduOp_b), .RegWr(RegWr_b), .PcWr(PcWr_b), .illegal(illegal_b), .busy(busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present one instruction to the main DUT; returns in the DECODE cycle.
    task automatic send(input logic [31:0] word);
        bif.inst       = word;
        bif.inst_valid = 1'b1;
        tick();
        bif.inst_valid = 1'b0;
        $display("send inst=%08h", word);
    endtask

    initial begin
        rst = 1'b0;
        bif.inst = 32'h0; bif.inst_valid = 1'b0; bif.lsu_req_ready = 1'b0;
        bif.lsu_resp_valid = 1'b0; bif.mdu_done = 1'b0;
        bif0.inst = 32'h0; bif0.inst_valid = 1'b0; bif0.lsu_req_ready = 1'b0;
        bif0.lsu_resp_valid = 1'b0; bif0.mdu_done = 1'b0;

        // reset with inst_valid asserted
        #2 rst = 1'b1;
        bif.inst = 32'h00500093; bif.inst_valid = 1'b1;
        tick();
        chk("rst_inst_ready", bif.inst_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pcwr", PcWr, 0);
        chk("rst_regwr", RegWr, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_lsu_req", bif.lsu_req_valid, 0);
        chk("rst_mdu_start", bif.mdu_start, 0);
        chk("rst_alubsrc", ALUBsrc, 0);
        rst = 1'b0; bif.inst_valid = 1'b0;
        #1;
        chk("post_rst_inst_ready", bif.inst_ready, 1);
        chk("post_rst_busy", busy, 0);
        tick();

        // addi x1, x0, 5
        send(32'h00500093);
        chk("addi_dec_busy", busy, 1);
        chk("addi_dec_ready", bif.inst_ready, 0);
        chk("addi_dec_pcwr", PcWr, 0);
        tick();
        chk("addi_extop", ExtOp, 3'b000);
        chk("addi_alubsrc", ALUBsrc, 2'b01);
        chk("addi_aluctr", ALUctr, 4'b0000);
        chk("addi_exec_regwr", RegWr, 0);
        chk("addi_exec_pcwr", PcWr, 0);
        tick();
        chk("addi_wb_regwr", RegWr, 1);
        chk("addi_wb_pcwr", PcWr, 1);
        tick();
        chk("addi_idle_pcwr", PcWr, 0);
        chk("addi_idle_regwr", RegWr, 0);
        chk("addi_idle_busy", busy, 0);
        chk("addi_idle_alubsrc", ALUBsrc, 0);
        chk("addi_idle_ready", bif.inst_ready, 1);

        // lw x2, 0(x1): accept after 3 request cycles, response in the 3rd wait cycle
        send(32'h0000A103);
        tick();
        chk("lw_memtoreg", MemtoReg, 1);
        chk("lw_memop", MemOp, 3'b010);
        chk("lw_exec_req", bif.lsu_req_valid, 0);
        tick();
        chk("lw_req_c1", bif.lsu_req_valid, 1);
        tick();
        chk("lw_req_c2", bif.lsu_req_valid, 1);
        tick();
        chk("lw_req_c3", bif.lsu_req_valid, 1);
        bif.lsu_req_ready = 1'b1; bif.lsu_resp_valid = 1'b1;
        tick();
        bif.lsu_req_ready = 1'b0; bif.lsu_resp_valid = 1'b0;
        chk("lw_wait_req", bif.lsu_req_valid, 0);
        chk("lw_wait_c1_regwr", RegWr, 0);
        chk("lw_wait_c1_pcwr", PcWr, 0);
        tick();
        chk("lw_wait_c2_regwr", RegWr, 0);
        tick();
        chk("lw_wait_c3_regwr", RegWr, 0);
        bif.lsu_resp_valid = 1'b1;
        tick();
        bif.lsu_resp_valid = 1'b0;
        chk("lw_wb_regwr", RegWr, 1);
        chk("lw_wb_pcwr", PcWr, 1);
        chk("lw_wb_memtoreg", MemtoReg, 1);
        tick();
        chk("lw_idle_regwr", RegWr, 0);
        chk("lw_idle_memtoreg", MemtoReg, 0);

        // bltu x1, x2, +8
        send(32'h0020E463);
        tick();
        chk("bltu_extop", ExtOp, 3'b011);
        chk("bltu_aluctr", ALUctr, 4'b1010);
        chk("bltu_branch", Branch, 3'b110);
        tick();
        chk("bltu_wb_regwr", RegWr, 0);
        chk("bltu_wb_pcwr", PcWr, 1);
        tick();

        // mul x3, x1, x2 with done in the 5th MDU_WAIT cycle
        send(32'h022081B3);
        chk("mul_dec_start", bif.mdu_start, 0);
        tick();
        chk("mul_exec_start", bif.mdu_start, 1);
        chk("mul_mduop", MduOp, 3'b000);
        chk("mul_alubsrc", ALUBsrc, 2'b00);
        tick();
        chk("mul_wait_start", bif.mdu_start, 0);
        for (int i = 2; i <= 5; i++) begin
            tick();
            chk("mul_wait_start_n", bif.mdu_start, 0);
            chk("mul_wait_regwr", RegWr, 0);
            if (i == 5) bif.mdu_done = 1'b1;
        end
        tick();
        bif.mdu_done = 1'b0;
        chk("mul_wb_regwr", RegWr, 1);
        chk("mul_wb_pcwr", PcWr, 1);
        tick();
        chk("mul_idle_busy", busy, 0);

        // same mul on the DUT without the M extension
        bif0.inst = 32'h022081B3; bif0.inst_valid = 1'b1;
        tick();
        bif0.inst_valid = 1'b0;
        tick();
        chk("nomext_illegal", illegal_b, 1);
        chk("nomext_pcwr", PcWr_b, 1);
        chk("nomext_start", bif0.mdu_start, 0);
        tick();
        chk("nomext_illegal_hold", illegal_b, 1);
        chk("nomext_pcwr_once", PcWr_b, 0);
        chk("nomext_ready", bif0.inst_ready, 0);

        // bad opcode traps and stays there until reset
        send(32'h0000007F);
        tick();
        chk("bad_illegal", illegal, 1);
        chk("bad_pcwr", PcWr, 1);
        chk("bad_regwr", RegWr, 0);
        bif.inst = 32'h00500093; bif.inst_valid = 1'b1;
        tick();
        chk("bad_illegal_hold", illegal, 1);
        chk("bad_pcwr_once", PcWr, 0);
        chk("bad_ready", bif.inst_ready, 0);
        tick();
        bif.inst_valid = 1'b0;
        chk("bad_still_trap", illegal, 1);
        #2 rst = 1'b1;
        #1;
        chk("bad_rst_illegal", illegal, 0);
        chk("bad_rst_busy", busy, 0);
        chk("bad_rst_illegal_b", illegal_b, 0);
        tick();
        rst = 1'b0;
        tick();

        // sw x2, 0(x1): reset asserted while the request is pending
        send(32'h0020A023);
        tick();
        chk("sw_memwr", MemWr, 1);
        chk("sw_extop", ExtOp, 3'b010);
        tick();
        chk("sw_req", bif.lsu_req_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("sw_rst_req", bif.lsu_req_valid, 0);
        chk("sw_rst_busy", busy, 0);
        chk("sw_rst_memwr", MemWr, 0);
        chk("sw_rst_ready", bif.inst_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("sw_post_rst_ready", bif.inst_ready, 1);
        tick();

        // ld (func3 011) is not a legal RV32 load
        send(32'h0000B103);
        tick();
        chk("ld_illegal", illegal, 1);
        chk("ld_pcwr", PcWr, 1);
        chk("ld_lsu_req", bif.lsu_req_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
